// File: rtl/ifu_prefetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches over a
// req/gnt/rvalid memory interface, buffers returned words with their PCs in a
// DEPTH-entry FIFO, and hands them to decode over valid/ready. A redirect
// flushes the FIFO and arranges for in-flight (stale) responses to be dropped.
//
// Handshakes: a transfer happens on a rising edge where the source's
// valid-type signal and the sink's ready-type signal are both high
// (imem_req/imem_gnt for fetch issue, ins_valid/ins_ready for decode pop);
// imem_rvalid has no back-pressure and is always accepted.
module ifu_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        ins_valid,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    input  logic        ins_ready,
    output logic        dbg_state
);

    localparam int          PW      = $clog2(DEPTH);
    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_V = (CW + 1)'(DEPTH);

    // FETCH: no stale responses owed; DRAIN: still dropping pre-redirect words
    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] live;
    logic [CW-1:0] next_outstanding;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [31:0]   ins_mem [DEPTH];
    logic [31:0]   pc_mem  [DEPTH];
    logic [31:0]   held_ins;
    logic [31:0]   held_pc;
    logic          grant;
    logic          push;
    logic          pop;
    logic          drop;

    // Credit: FIFO space must cover every word that will actually be kept
    assign live      = outstanding - discard;
    assign imem_req  = !reset && !redirect &&
                       (({1'b0, count} + {1'b0, live}) < DEPTH_V);
    assign imem_addr = fetch_pc;
    assign grant     = imem_req && imem_gnt;

    assign drop = imem_rvalid && (discard != '0);
    assign push = imem_rvalid && (discard == '0) && !redirect;
    assign pop  = ins_valid && ins_ready && !redirect;

    // A response in the redirect cycle already leaves outstanding here, so
    // this is also the stale count to discard on a redirect.
    assign next_outstanding = outstanding + CW'(grant) - CW'(imem_rvalid);

    assign ins_valid = (count != '0);
    assign ins       = ins_valid ? ins_mem[head] : held_ins;
    assign ins_pc    = ins_valid ? pc_mem[head]  : held_pc;
    assign dbg_state = state;

    // FIFO storage writes; contents are only observed once count covers them
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            ins_mem[tail] <= imem_rdata;
            pc_mem[tail]  <= resp_pc;
        end
    end

    // Fetch PC, response PC, occupancy, credit counters and drain state
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            head        <= '0;
            tail        <= '0;
            held_ins    <= '0;
            held_pc     <= RESET_PC;
        end else begin
            outstanding <= next_outstanding;
            if (ins_valid) begin
                held_ins <= ins_mem[head];
                held_pc  <= pc_mem[head];
            end
            if (redirect) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                resp_pc  <= {redirect_pc[31:2], 2'b00};
                count    <= '0;
                tail     <= head;
                discard  <= next_outstanding;
                state    <= (next_outstanding != '0) ? DRAIN : FETCH;
            end else begin
                if (grant) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (drop) begin
                    discard <= discard - 1'b1;
                    if (discard == CW'(1)) begin
                        state <= FETCH;
                    end
                end
                if (push) begin
                    tail    <= tail + 1'b1;
                    resp_pc <= resp_pc + 32'd4;
                end
                if (pop) begin
                    head <= head + 1'b1;
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

endmodule

// File: tb/tb_ifu_prefetch_queue.sv
// Bench for ifu_prefetch_queue. The reference model tracks fetch "epochs":
// every redirect starts a new epoch, a response is kept only if its request
// was granted in the current epoch, and the FIFO is a queue of kept PCs.
module tb_ifu_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ins_valid;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        ins_ready;
    logic        dbg_state;

    ifu_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .ins_valid(ins_valid), .ins(ins), .ins_pc(ins_pc),
        .ins_ready(ins_ready), .dbg_state(dbg_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          ep;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] exp_q[$];
    logic [31:0] pop_log[$];
    logic [31:0] grant_log[$];
    int          epoch;
    logic [31:0] fetch_addr;
    logic [31:0] data_xor;
    int          cyc;
    int          n_checks;
    int          n_errors;

    int          gnt_pct, rv_pct, rdy_pct, redir_pm, lat_min, lat_max;
    logic        redir_now;
    logic [31:0] redir_target;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int live_cnt();
        int n = 0;
        foreach (pend[i]) if (pend[i].ep == epoch) n++;
        return n;
    endfunction

    function automatic logic stale_any();
        foreach (pend[i]) if (pend[i].ep != epoch) return 1'b1;
        return 1'b0;
    endfunction

    // driver: synchronous reset, check reset values, reset the model
    task automatic do_reset();
        reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; ins_ready = 1'b0;
        @(posedge clk); #1;
        chk("rst_req", imem_req, 1'b0);
        chk("rst_valid", ins_valid, 1'b0);
        chk("rst_ins", ins, 32'h0);
        chk("rst_ins_pc", ins_pc, RESET_PC);
        chk("rst_state", dbg_state, 1'b0);
        chk("rst_addr", imem_addr, RESET_PC);
        pend.delete(); exp_q.delete(); pop_log.delete(); grant_log.delete();
        epoch++;
        fetch_addr = RESET_PC;
        reset = 1'b0;
    endtask

    // driver + scoreboard for one clock cycle
    task automatic step();
        logic  m_req;
        logic  kept;
        pend_t r;
        imem_gnt = ($urandom_range(99) < gnt_pct);
        if (pend.size() > 0 && pend[0].due <= cyc && $urandom_range(99) < rv_pct) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend[0].addr ^ data_xor;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        redirect    = redir_now || ($urandom_range(999) < redir_pm);
        redirect_pc = redir_now ? redir_target : $urandom;
        ins_ready   = ($urandom_range(99) < rdy_pct);
        #1;
        m_req = !redirect && (exp_q.size() + live_cnt() < DEPTH);
        chk("imem_req", imem_req, m_req);
        chk("imem_addr", imem_addr, fetch_addr);
        chk("ins_valid", ins_valid, exp_q.size() != 0);
        chk("state", dbg_state, stale_any());
        if (exp_q.size() != 0) begin
            chk("ins_pc", ins_pc, exp_q[0]);
            chk("ins", ins, exp_q[0] ^ data_xor);
        end
        kept = 1'b0;
        if (imem_rvalid) begin
            r = pend.pop_front();
            kept = (r.ep == epoch) && !redirect;
        end
        if (redirect) begin
            epoch++;
            fetch_addr = {redirect_pc[31:2], 2'b00};
            exp_q.delete();
        end else begin
            if (exp_q.size() != 0 && ins_ready) pop_log.push_back(exp_q.pop_front());
            if (kept) exp_q.push_back(r.addr);
            if (m_req && imem_gnt) begin
                pend.push_back('{addr: fetch_addr, ep: epoch,
                                 due: cyc + $urandom_range(lat_max, lat_min)});
                grant_log.push_back(fetch_addr);
                fetch_addr = fetch_addr + 32'd4;
            end
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic knobs(input int g, input int rv, input int rd, input int lmin, input int lmax);
        gnt_pct = g; rv_pct = rv; rdy_pct = rd; lat_min = lmin; lat_max = lmax;
    endtask

    function automatic logic [31:0] log_at(input int idx, input logic is_pop);
        if (is_pop) return (pop_log.size() > idx) ? pop_log[idx] : 32'hDEAD_BEEF;
        return (grant_log.size() > idx) ? grant_log[idx] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        n_checks = 0; n_errors = 0; cyc = 0; epoch = 0;
        redir_now = 1'b0; redir_target = '0; redir_pm = 0; data_xor = '0;
        knobs(100, 100, 100, 1, 1);

        // streaming, 1-cycle memory returning the address as data
        do_reset();
        run(12);
        chk("t1_npops", pop_log.size(), 10);
        chk("t1_pop0", log_at(0, 1), 32'h3000);
        chk("t1_pop1", log_at(1, 1), 32'h3004);
        chk("t1_pop2", log_at(2, 1), 32'h3008);

        // decode stalled: FIFO fills, requests stop, then drains in order
        do_reset();
        knobs(100, 100, 0, 1, 1);
        run(10);
        chk("t2_grants", grant_log.size(), 4);
        chk("t2_g3", log_at(3, 0), 32'h300C);
        chk("t2_req_low", imem_req, 1'b0);
        chk("t2_head", ins_pc, 32'h3000);
        knobs(0, 100, 100, 1, 1);
        run(6);
        chk("t2_npops", pop_log.size(), 4);
        for (int i = 0; i < 4; i++) chk("t2_pop", log_at(i, 1), 32'h3000 + 32'(4 * i));

        // redirect with three fetches in flight on a 3-cycle memory
        do_reset();
        data_xor = 32'h5A5A_0000;
        knobs(100, 100, 0, 3, 3);
        run(3);
        rv_pct = 0; redir_now = 1'b1; redir_target = 32'h4002;
        step();
        redir_now = 1'b0;
        chk("t3_addr", imem_addr, 32'h4000);
        chk("t3_state", dbg_state, 1'b1);
        pop_log.delete();
        knobs(100, 100, 100, 3, 3);
        run(15);
        chk("t3_first", log_at(0, 1), 32'h4000);
        chk("t3_second", log_at(1, 1), 32'h4004);

        // redirect coinciding with a response and a pop, two in flight
        do_reset();
        knobs(100, 100, 0, 2, 2);
        step();
        gnt_pct = 0;   step();
        gnt_pct = 100; step();
        step();
        rdy_pct = 100; redir_now = 1'b1; redir_target = 32'h5000;
        step();
        redir_now = 1'b0;
        chk("t4_empty", ins_valid, 1'b0);
        chk("t4_drain", dbg_state, 1'b1);
        pop_log.delete();
        run(10);
        chk("t4_first", log_at(0, 1), 32'h5000);

        // fetch PC wraps past the top of the address space
        do_reset();
        knobs(0, 100, 0, 1, 1);
        redir_now = 1'b1; redir_target = 32'hFFFF_FFFC;
        step();
        redir_now = 1'b0;
        knobs(100, 0, 0, 1, 1);
        step();
        chk("t5_wrap", imem_addr, 32'h0000_0000);
        knobs(100, 100, 100, 1, 1);
        run(6);
        chk("t5_pop0", log_at(0, 1), 32'hFFFF_FFFC);
        chk("t5_pop1", log_at(1, 1), 32'h0000_0000);

        // random traffic with a reset in the middle
        for (int half = 0; half < 2; half++) begin
            do_reset();
            data_xor = $urandom;
            knobs(70, 60, 60, 1, 4);
            redir_pm = 20;
            run(5000);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
